// File: rtl/tc_int_mma_engine_if.sv
// Request/result bus between the warp issue stage, the integer tile engine and writeback.
interface tc_int_mma_engine_if #(
    parameter int SHAPE_M    = 8,
    parameter int SHAPE_N    = 8,
    parameter int SHAPE_K    = 8,
    parameter int IN_W       = 8,
    parameter int OUT_W      = 16,
    parameter int DEPTH_WARP = 3
);
    logic                              in_valid_i;
    logic                              in_ready_o;
    logic [SHAPE_M*SHAPE_K*IN_W-1:0]   a_i;
    logic [SHAPE_K*SHAPE_N*IN_W-1:0]   b_i;
    logic [SHAPE_M*SHAPE_N*OUT_W-1:0]  c_i;
    logic                              signed_i;
    logic                              sat_i;
    logic [DEPTH_WARP-1:0]             warpid_i;
    logic [7:0]                        reg_idxw_i;
    logic                              out_valid_o;
    logic                              out_ready_i;
    logic [SHAPE_M*SHAPE_N*OUT_W-1:0]  d_o;
    logic [SHAPE_M*SHAPE_N-1:0]        ovf_o;
    logic [DEPTH_WARP-1:0]             ctrl_warpid_o;
    logic [7:0]                        ctrl_reg_idxw_o;

    modport master (
        output in_valid_i, a_i, b_i, c_i, signed_i, sat_i, warpid_i, reg_idxw_i, out_ready_i,
        input  in_ready_o, out_valid_o, d_o, ovf_o, ctrl_warpid_o, ctrl_reg_idxw_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, c_i, signed_i, sat_i, warpid_i, reg_idxw_i, out_ready_i,
        output in_ready_o, out_valid_o, d_o, ovf_o, ctrl_warpid_o, ctrl_reg_idxw_o
    );
endinterface

// File: rtl/tc_int_mma_engine.sv
// Integer tile engine computing D = A*B + C, one K step per cycle on an M x N MAC array.
// Define TC_SAT_EN to build the optional per-element saturation (clamp) logic.
module tc_int_mma_engine #(
    parameter int SHAPE_M    = 8,
    parameter int SHAPE_N    = 8,
    parameter int SHAPE_K    = 8,
    parameter int IN_W       = 8,
    parameter int OUT_W      = 16,
    parameter int DEPTH_WARP = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tc_int_mma_engine_if.slave    bus
);
    localparam int ACC_W = 2*IN_W + $clog2(SHAPE_K) + 1;
    localparam int K_W   = $clog2(SHAPE_K);
    localparam logic [K_W-1:0] K_LAST = K_W'(SHAPE_K - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t                          state_q;
    state_t                          state_d;
    logic [K_W-1:0]                  k_q;
    logic                            accept;
    logic                            last_step;
    logic [SHAPE_M*SHAPE_K*IN_W-1:0] a_q;
    logic [SHAPE_K*SHAPE_N*IN_W-1:0] b_q;
    logic                            signed_q;
    logic [DEPTH_WARP-1:0]           warpid_q;
    logic [7:0]                      reg_idxw_q;

    // rst_n is active-high here, so the engine is only ready while it is low.
    always_comb begin
        state_d        = state_q;
        bus.in_ready_o = 1'b0;
        accept         = 1'b0;
        last_step      = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready_o = ~rst_n;
                accept         = bus.in_valid_i & ~rst_n;
                if (accept) state_d = COMPUTE;
            end
            COMPUTE: begin
                last_step = (k_q == K_LAST);
                if (last_step) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            signed_q   <= 1'b0;
            warpid_q   <= '0;
            reg_idxw_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                k_q        <= '0;
                a_q        <= bus.a_i;
                b_q        <= bus.b_i;
                signed_q   <= bus.signed_i;
                warpid_q   <= bus.warpid_i;
                reg_idxw_q <= bus.reg_idxw_i;
            end else if (state_q == COMPUTE) begin
                k_q <= last_step ? '0 : k_q + 1'b1;
            end
        end
    end

`ifdef TC_SAT_EN
    logic sat_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sat_q <= 1'b0;
        end else if (accept) begin
            sat_q <= bus.sat_i;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = bus.sat_i;
`endif

    assign bus.out_valid_o     = (state_q == DONE);
    assign bus.ctrl_warpid_o   = warpid_q;
    assign bus.ctrl_reg_idxw_o = reg_idxw_q;

    for (genvar gi = 0; gi < SHAPE_M; gi++) begin : g_row
        for (genvar gj = 0; gj < SHAPE_N; gj++) begin : g_col
            localparam int E = gi*SHAPE_N + gj;

            logic [IN_W-1:0]  a_el;
            logic [IN_W-1:0]  b_el;
            logic [OUT_W-1:0] c_el;
            logic [ACC_W-1:0] a_ext;
            logic [ACC_W-1:0] b_ext;
            logic [ACC_W-1:0] c_ext;
            logic [ACC_W-1:0] acc_q;
            logic [ACC_W-1:0] acc_nxt;
            logic [OUT_W-1:0] d_q;
            logic [OUT_W-1:0] d_nxt;
            logic             ovf_q;
            logic             ovf_nxt;

            // Operands are extended to ACC_W so one modular multiply covers both modes.
            assign a_el    = a_q[(gi*SHAPE_K + int'(k_q))*IN_W +: IN_W];
            assign b_el    = b_q[(int'(k_q)*SHAPE_N + gj)*IN_W +: IN_W];
            assign c_el    = bus.c_i[E*OUT_W +: OUT_W];
            assign a_ext   = {{(ACC_W-IN_W){signed_q & a_el[IN_W-1]}}, a_el};
            assign b_ext   = {{(ACC_W-IN_W){signed_q & b_el[IN_W-1]}}, b_el};
            assign c_ext   = {{(ACC_W-OUT_W){bus.signed_i & c_el[OUT_W-1]}}, c_el};
            assign acc_nxt = acc_q + a_ext * b_ext;

            always_comb begin
                d_nxt   = acc_nxt[OUT_W-1:0];
                ovf_nxt = 1'b0;
                if (signed_q) begin
                    ovf_nxt = ~((&acc_nxt[ACC_W-1:OUT_W-1]) | ~(|acc_nxt[ACC_W-1:OUT_W-1]));
                end else begin
                    ovf_nxt = |acc_nxt[ACC_W-1:OUT_W];
                end
`ifdef TC_SAT_EN
                if (sat_q && ovf_nxt) begin
                    if (!signed_q) begin
                        d_nxt = '1;
                    end else if (acc_nxt[ACC_W-1]) begin
                        d_nxt = {1'b1, {(OUT_W-1){1'b0}}};
                    end else begin
                        d_nxt = {1'b0, {(OUT_W-1){1'b1}}};
                    end
                end
`endif
            end

            // The final step's sum goes straight into the output register as DONE is entered.
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    acc_q <= '0;
                    d_q   <= '0;
                    ovf_q <= 1'b0;
                end else begin
                    if (accept) begin
                        acc_q <= c_ext;
                    end else if (state_q == COMPUTE) begin
                        acc_q <= acc_nxt;
                    end
                    if (state_q == COMPUTE && last_step) begin
                        d_q   <= d_nxt;
                        ovf_q <= ovf_nxt;
                    end
                end
            end

            assign bus.d_o[E*OUT_W +: OUT_W] = d_q;
            assign bus.ovf_o[E]              = ovf_q;
        end
    end
endmodule

// File: tb/tb_tc_int_mma_engine.sv
// Directed scoreboard bench for tc_int_mma_engine: functional, overflow, backpressure and reset cases.
module tb_tc_int_mma_engine;
    localparam int M  = 8;
    localparam int N  = 8;
    localparam int K  = 8;
    localparam int IW = 8;
    localparam int OW = 16;
    localparam int DW = 3;

    typedef struct {
        logic [M*N*OW-1:0] d;
        logic [M*N-1:0]    ovf;
        logic [DW-1:0]     wid;
        logic [7:0]        ridx;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc          = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   accept_cyc   = 0;
    int   ta [M][K];
    int   tbm[K][N];
    int   tc [M][N];
    exp_t sb[$];

    tc_int_mma_engine_if #(.SHAPE_M(M), .SHAPE_N(N), .SHAPE_K(K), .IN_W(IW), .OUT_W(OW),
                           .DEPTH_WARP(DW)) bus();

    tc_int_mma_engine #(.SHAPE_M(M), .SHAPE_N(N), .SHAPE_K(K), .IN_W(IW), .OUT_W(OW),
                        .DEPTH_WARP(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input int v, input int w, input bit sgn);
        longint x;
        x = longint'(v) & ((longint'(1) << w) - 1);
        if (sgn && x >= (longint'(1) << (w-1))) x -= (longint'(1) << w);
        return x;
    endfunction

    // Reference model: exact 64-bit sums, then range check and wrap/clamp to 16 bits.
    function automatic exp_t model(input bit sgn, input bit sat, input logic [DW-1:0] wid,
                                   input logic [7:0] ridx);
        exp_t        e;
        longint      s;
        logic [63:0] sv;
        logic [OW-1:0] dv;
        bit          ov;
        e.d    = '0;
        e.ovf  = '0;
        e.wid  = wid;
        e.ridx = ridx;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                s = sx(tc[i][j], OW, sgn);
                for (int k = 0; k < K; k++) s += sx(ta[i][k], IW, sgn) * sx(tbm[k][j], IW, sgn);
                ov = sgn ? (s < -32768 || s > 32767) : (s > 65535);
                sv = s;
                dv = sv[OW-1:0];
`ifdef TC_SAT_EN
                if (sat && ov) dv = sgn ? ((s < 0) ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
`endif
                e.d[(i*N+j)*OW +: OW] = dv;
                e.ovf[i*N+j]          = ov;
            end
        end
        return e;
    endfunction

    function automatic void fillTest1();
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ta[i][k] = i + k;
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) tbm[k][j] = k + j;
        for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) tc[i][j] = 0;
    endfunction

    function automatic void fillConst(input int av, input int bv, input int cv);
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ta[i][k] = av;
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) tbm[k][j] = bv;
        for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) tc[i][j] = cv;
    endfunction

    function automatic void fillRandom();
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ta[i][k] = int'($urandom_range(0, 255));
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) tbm[k][j] = int'($urandom_range(0, 255));
        for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) tc[i][j] = int'($urandom_range(0, 65535));
    endfunction

    task automatic driveTile(input bit sgn, input bit sat, input logic [DW-1:0] wid,
                             input logic [7:0] ridx);
        logic [M*K*IW-1:0] a;
        logic [K*N*IW-1:0] b;
        logic [M*N*OW-1:0] c;
        logic [31:0]       v;
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) begin
            v = 32'(ta[i][k]);
            a[(i*K+k)*IW +: IW] = v[IW-1:0];
        end
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) begin
            v = 32'(tbm[k][j]);
            b[(k*N+j)*IW +: IW] = v[IW-1:0];
        end
        for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) begin
            v = 32'(tc[i][j]);
            c[(i*N+j)*OW +: OW] = v[OW-1:0];
        end
        bus.a_i        = a;
        bus.b_i        = b;
        bus.c_i        = c;
        bus.signed_i   = sgn;
        bus.sat_i      = sat;
        bus.warpid_i   = wid;
        bus.reg_idxw_i = ridx;
        bus.in_valid_i = 1'b1;
        sb.push_back(model(sgn, sat, wid, ridx));
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic applyStimulus(input bit sgn, input bit sat, input logic [DW-1:0] wid,
                                 input logic [7:0] ridx);
        int w = 0;
        driveTile(sgn, sat, wid, ridx);
        while (bus.in_ready_o !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", 64'(bus.in_ready_o), 64'd1);
        accept_cyc = cyc + 1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic waitValid(input string tag);
        int w = 0;
        while (bus.out_valid_o !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_valid"}, 64'(bus.out_valid_o), 64'd1);
    endtask

    task automatic compareFront(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb[0];
        check({tag, "_ovf"}, 64'(bus.ovf_o), 64'(e.ovf));
        check({tag, "_warpid"}, 64'(bus.ctrl_warpid_o), 64'(e.wid));
        check({tag, "_reg_idxw"}, 64'(bus.ctrl_reg_idxw_o), 64'(e.ridx));
        for (int el = 0; el < M*N; el++) begin
            check($sformatf("%s_d%0d", tag, el), 64'(bus.d_o[el*OW +: OW]), 64'(e.d[el*OW +: OW]));
        end
    endtask

    // Compares the held result, lets it transfer (out_ready_i high) and retires it.
    task automatic checkOutput(input string tag);
        compareFront(tag);
        @(negedge clk);
        check({tag, "_valid_fall"}, 64'(bus.out_valid_o), 64'd0);
        check({tag, "_ready_rise"}, 64'(bus.in_ready_o), 64'd1);
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.c_i         = '0;
        bus.signed_i    = 1'b0;
        bus.sat_i       = 1'b0;
        bus.warpid_i    = '0;
        bus.reg_idxw_i  = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_ovf", 64'(bus.ovf_o), 64'd0);
        check("rst_warpid", 64'(bus.ctrl_warpid_o), 64'd0);
        check("rst_reg_idxw", 64'(bus.ctrl_reg_idxw_o), 64'd0);
        for (int el = 0; el < M*N; el++) check($sformatf("rst_d%0d", el), 64'(bus.d_o[el*OW +: OW]), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready_o), 64'd1);

        $display("[TB] unsigned functional tile");
        fillTest1();
        applyStimulus(1'b0, 1'b0, 3'd1, 8'h10);
        waitValid("t1");
        check("t1_latency", 64'(cyc - accept_cyc), 64'(K));
        check("t1_d00", 64'(bus.d_o[0 +: OW]), 64'd140);
        check("t1_d77", 64'(bus.d_o[(M*N-1)*OW +: OW]), 64'd924);
        checkOutput("t1");

        $display("[TB] signed functional tile");
        fillConst(8'hFF, 8'h02, 16'h0003);
        applyStimulus(1'b1, 1'b0, 3'd2, 8'h20);
        waitValid("t2");
        check("t2_d00", 64'(bus.d_o[0 +: OW]), 64'hFFF3);
        checkOutput("t2");

        $display("[TB] unsigned overflow tile");
        fillConst(8'hFF, 8'hFF, 0);
        applyStimulus(1'b0, 1'b1, 3'd3, 8'h30);
        waitValid("t3");
`ifdef TC_SAT_EN
        check("t3_d00", 64'(bus.d_o[0 +: OW]), 64'hFFFF);
`else
        check("t3_d00", 64'(bus.d_o[0 +: OW]), 64'hF008);
`endif
        check("t3_ovf_all", 64'(bus.ovf_o), {64{1'b1}});
        checkOutput("t3");

        $display("[TB] signed overflow tile");
        fillConst(8'h80, 8'h80, 0);
        applyStimulus(1'b1, 1'b1, 3'd4, 8'h40);
        waitValid("t4");
        checkOutput("t4");

        $display("[TB] backpressure with a queued request");
        fillTest1();
        applyStimulus(1'b0, 1'b0, 3'd1, 8'h11);
        waitValid("bp_x");
        bus.out_ready_i = 1'b0;
        fillRandom();
        driveTile(1'b0, 1'b0, 3'd5, 8'h2A);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(bus.out_valid_o), 64'd1);
            check("bp_hold_ready", 64'(bus.in_ready_o), 64'd0);
            compareFront($sformatf("bp_hold%0d", c));
        end
        bus.out_ready_i = 1'b1;
        checkOutput("bp_x");
        accept_cyc = cyc + 1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        check("bp_y_accepted", 64'(bus.in_ready_o), 64'd0);
        waitValid("bp_y");
        check("bp_y_latency", 64'(cyc - accept_cyc), 64'(K));
        check("bp_y_warpid", 64'(bus.ctrl_warpid_o), 64'd5);
        check("bp_y_reg_idxw", 64'(bus.ctrl_reg_idxw_o), 64'h2A);
        checkOutput("bp_y");

        $display("[TB] reset during compute");
        fillTest1();
        applyStimulus(1'b0, 1'b0, 3'd6, 8'h33);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid_o), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready_o), 64'd0);
        check("mid_rst_ovf", 64'(bus.ovf_o), 64'd0);
        check("mid_rst_warpid", 64'(bus.ctrl_warpid_o), 64'd0);
        for (int el = 0; el < M*N; el++) check($sformatf("mid_rst_d%0d", el), 64'(bus.d_o[el*OW +: OW]), 64'd0);
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3'd7, 8'h44);
        waitValid("t6");
        check("t6_latency", 64'(cyc - accept_cyc), 64'(K));
        check("t6_d00", 64'(bus.d_o[0 +: OW]), 64'd140);
        checkOutput("t6");
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
